// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: raster control, sprite descriptors and composited pixel/collision outputs
interface sprite_compositor_if #(
  parameter int N_SPR = 4,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int CW    = 8
);
  logic                  data_enable;
  logic                  frame;
  logic [N_SPR-1:0]      spr_en;
  logic [N_SPR*XW-1:0]   spr_x;
  logic [N_SPR*YW-1:0]   spr_y;
  logic [N_SPR*XW-1:0]   spr_w;
  logic [N_SPR*YW-1:0]   spr_h;
  logic [N_SPR*CW-1:0]   spr_color;
  logic [CW-1:0]         bg_color;
  logic [CW-1:0]         vga_out;
  logic                  pixel_valid;
  logic [XW-1:0]         pixel_x;
  logic [YW-1:0]         pixel_y;
  logic [N_SPR-2:0]      player_collision;
  logic                  coll_any;
  modport master (
    output data_enable, frame, spr_en, spr_x, spr_y, spr_w, spr_h, spr_color, bg_color,
    input  vga_out, pixel_valid, pixel_x, pixel_y, player_collision, coll_any
  );
  modport slave (
    input  data_enable, frame, spr_en, spr_x, spr_y, spr_w, spr_h, spr_color, bg_color,
    output vga_out, pixel_valid, pixel_x, pixel_y, player_collision, coll_any
  );
endinterface

// File: rtl/sprite_compositor.sv
// sprite_compositor: priority-composites N_SPR rectangular sprites over the raster and flags player collisions per frame
module sprite_compositor #(
  parameter int N_SPR = 4,
  parameter int RES_H = 640,
  parameter int RES_V = 480,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int CW    = 8
) (
  input logic             clk,
  input logic             rst_n,
  sprite_compositor_if.slave bus
);
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [N_SPR-1:0] hit_c, hit;
  logic             de_d1;
  logic [CW-1:0]    col_c, vga;
  logic             pv;
  logic [N_SPR-2:0] acc, acc_nx, pc;
  logic             any;
  wire              x_last = x == XW'(RES_H - 1);
  wire              y_last = y == YW'(RES_V - 1);
  for (genvar k = 0; k < N_SPR; k++) begin : g_hit
    logic [XW:0] x_end;
    logic [YW:0] y_end;
    assign x_end = {1'b0, bus.spr_x[k*XW +: XW]} + {1'b0, bus.spr_w[k*XW +: XW]};
    assign y_end = {1'b0, bus.spr_y[k*YW +: YW]} + {1'b0, bus.spr_h[k*YW +: YW]};
    assign hit_c[k] = bus.spr_en[k] && x >= bus.spr_x[k*XW +: XW] && {1'b0, x} < x_end
                      && y >= bus.spr_y[k*YW +: YW] && {1'b0, y} < y_end;
  end
  // lowest-index hitting channel wins, background otherwise
  always_comb begin
    col_c = bus.bg_color;
    for (int k = N_SPR - 1; k >= 0; k--)
      if (hit[k]) col_c = bus.spr_color[k*CW +: CW];
  end
  assign acc_nx = acc | ({(N_SPR-1){de_d1 & hit[0]}} & hit[N_SPR-1:1]);
  // raster counters; frame restarts the scan and overrides data_enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (bus.frame) begin
      x <= '0;
      y <= '0;
    end else if (bus.data_enable) begin
      x <= x_last ? '0 : x + 1'b1;
      if (x_last) y <= y_last ? '0 : y + 1'b1;
    end
  end
  // two-stage pixel pipeline: hit test, then colour select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit   <= '0;
      de_d1 <= 1'b0;
      vga   <= '0;
      pv    <= 1'b0;
    end else begin
      hit   <= hit_c;
      de_d1 <= bus.data_enable;
      vga   <= de_d1 ? col_c : '0;
      pv    <= de_d1;
    end
  end
  // collision accumulator, published and cleared on each frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      pc  <= '0;
      any <= 1'b0;
    end else if (bus.frame) begin
      pc  <= acc_nx;
      any <= |acc_nx;
      acc <= '0;
    end else begin
      acc <= acc_nx;
    end
  end
  assign bus.pixel_x          = x;
  assign bus.pixel_y          = y;
  assign bus.vga_out          = vga;
  assign bus.pixel_valid      = pv;
  assign bus.player_collision = pc;
  assign bus.coll_any         = any;
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised multi-channel successor to the single-player/laser pixel path.
- Walks the active raster using the timing block's data_enable.
- Tests N_SPR rectangular sprite channels per pixel and resolves overlaps by fixed priority: lower index wins.
- Emits an RRRGGGBB pixel and per-frame, double-buffered collision flags between channel 0 (player) and every other channel.

Parameters:
- N_SPR, 4, number of sprite channels (2..8); channel 0 is the collision reference.
- RES_H, 640, active pixels per line.
- RES_V, 480, active lines per frame.
- XW, 10, width of x coordinates and sprite widths.
- YW, 10, width of y coordinates and sprite heights.
- CW, 8, colour width (RRRGGGBB).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_enable  in  1  active-video qualifier from the timing block.
- frame  in  1  one-cycle frame-start pulse, asserted only in blanking.
- spr_en  in  N_SPR  per-channel enable.
- spr_x  in  N_SPR*XW  packed left edges; channel k at bits [k*XW +: XW].
- spr_y  in  N_SPR*YW  packed top edges.
- spr_w  in  N_SPR*XW  packed widths in pixels (already scaled).
- spr_h  in  N_SPR*YW  packed heights in lines.
- spr_color  in  N_SPR*CW  packed colours.
- bg_color  in  CW  colour when no sprite hits.
- vga_out  out  CW  composited pixel.
- pixel_valid  out  1  vga_out qualifier.
- pixel_x  out  XW  current raster x (stage 0).
- pixel_y  out  YW  current raster y (stage 0).
- player_collision  out  N_SPR-1  bit k-1 set = channel 0 overlapped channel k in the previous frame.
- coll_any  out  1  OR of player_collision.

Behaviour:
- Reset (rst_n low, asynchronous): pixel_x=0, pixel_y=0, vga_out=0, pixel_valid=0, player_collision=0, coll_any=0, all pipeline and accumulator registers 0.
- Raster counters: advance only when data_enable=1.
  - x wraps RES_H-1 -> 0 and increments y.
  - y wraps RES_V-1 -> 0.
  - frame=1 forces x=y=0 synchronously; frame has priority over data_enable.
- Pipeline, 2 cycles from counter value to vga_out:
  - Stage 1 registers hit[k] = spr_en[k] && x>=spr_x[k] && x<spr_x[k]+spr_w[k] && y>=spr_y[k] && y<spr_y[k]+spr_h[k]; registers de_d1 = data_enable.
  - Stage 2 registers vga_out = spr_color[lowest k with hit[k]], else bg_color, when de_d1=1; vga_out=0 when de_d1=0. pixel_valid = de_d1.
- Edge arithmetic:
  - Sums use XW+1 / YW+1 bits, so no wrap.
  - Half-open bounds: a sprite of width w covers exactly w pixels; w=0 or h=0 draws nothing.
  - A sprite extending past RES_H-1 or RES_V-1 is clipped, not wrapped.
- Sprite inputs are sampled live each cycle; changes mid-frame take effect on the next stage-1 evaluation (no shadowing).
- Collisions:
  - Accumulator acc[k-1] |= hit[0] && hit[k], evaluated on stage-1 hits while de_d1=1.
  - On frame: player_collision <= acc (including the current cycle's term), acc <= 0. coll_any is registered with player_collision.
  - Frame coinciding with de_d1=1 is a contract violation; the required result is still the defined one (term folded into the published value, then cleared).
- Overlap among non-zero channels affects priority only, never collision flags.
- Reset mid-frame: counters restart at 0; accumulated collisions are lost; the first frame pulse after reset publishes only hits seen since reset.

Test Plan:
- Reset, then 2 frames with all spr_en=0 and bg_color=8'h03: every valid vga_out=8'h03; pixel_valid tracks data_enable delayed by 2; player_collision=0.
- Channel 1 at x=100, y=50, w=8, h=4, colour 8'hE0: x=99 and x=108 give background; x=100..107 on lines 50..53 give 8'hE0, two cycles after the counter value; line 54 gives background.
- Channel 0 (8'h1C) and channel 2 (8'hFF) overlap at (200,200) size 4x4: overlap pixels show 8'h1C. After the next frame pulse, player_collision=3'b010 and coll_any=1. After one further frame without overlap, both are 0.
- Sprite at x=636, w=8 on RES_H=640: pixels 636..639 drawn; x=0..3 of the next line not drawn.
- Assert rst_n low at (320,240) mid-frame: all outputs 0 immediately (asynchronous); after release, counters start at 0; collisions from before reset are not reported.
- frame pulse while pixel_x=150: counters return to 0 next cycle; the pending accumulator is published and cleared.
